// File: rtl/gsim_host_link.sv
// rtl/gsim_host_link.sv - host-side b loader / x capture partner for the Gauss-Seidel solver core
module gsim_host_link #(
    parameter int N       = 16,
    parameter int B_W     = 16,
    parameter int X_W     = 32,
    parameter int TIMEOUT = 100000,
    parameter int CNT_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [B_W-1:0]   wr_data,
    input  logic             start,
    input  logic [3:0]       rd_addr,
    output logic [X_W-1:0]   rd_data,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_short,
    output logic             gs_in_en,
    output logic [B_W-1:0]   gs_b_in,
    input  logic             gs_out_valid,
    input  logic [X_W-1:0]   gs_x_out
);
    localparam int IDX_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   scnt_q, scnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic               err_t_q, err_t_d;
    logic               err_s_q, err_s_d;
    logic               en_q, en_d;
    logic [B_W-1:0]     b_q, b_d;
    logic [X_W-1:0]     rd_q;
    logic [B_W-1:0]     bbuf_q [N];
    logic [X_W-1:0]     xbuf_q [N];
    logic               b_we;
    logic               x_we;
    logic [3:0]         x_waddr;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        err_t_d = err_t_q;
        err_s_d = err_s_q;
        en_d    = en_q;
        b_d     = b_q;
        b_we    = 1'b0;
        x_we    = 1'b0;
        x_waddr = idx_q[3:0];
        case (state_q)
            S_IDLE, S_DONE: begin
                b_we = wr_en;
                if (start) begin
                    // First element goes out on the cycle right after start
                    state_d = S_SEND;
                    err_t_d = 1'b0;
                    err_s_d = 1'b0;
                    tcnt_d  = '0;
                    idx_d   = '0;
                    scnt_d  = IDX_W'(1);
                    en_d    = 1'b1;
                    b_d     = bbuf_q[0];
                end
            end
            S_SEND: begin
                if (scnt_q == IDX_W'(N)) begin
                    en_d    = 1'b0;
                    b_d     = '0;
                    state_d = S_WAIT;
                end else begin
                    b_d    = bbuf_q[scnt_q[3:0]];
                    scnt_d = scnt_q + IDX_W'(1);
                end
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + CNT_W'(1);
                if (gs_out_valid) begin
                    x_we    = 1'b1;
                    x_waddr = 4'd0;
                    idx_d   = IDX_W'(1);
                    state_d = S_RECV;
                end else if (tcnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_t_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RECV: begin
                if (gs_out_valid) begin
                    x_we  = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    err_s_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            scnt_q  <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            err_t_q <= 1'b0;
            err_s_q <= 1'b0;
            en_q    <= 1'b0;
            b_q     <= '0;
            rd_q    <= '0;
            for (int i = 0; i < N; i++) begin
                bbuf_q[i] <= '0;
                xbuf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            err_t_q <= err_t_d;
            err_s_q <= err_s_d;
            en_q    <= en_d;
            b_q     <= b_d;
            rd_q    <= xbuf_q[rd_addr];
            if (b_we) begin
                bbuf_q[wr_addr] <= wr_data;
            end
            if (x_we) begin
                xbuf_q[x_waddr] <= gs_x_out;
            end
        end
    end

    assign rd_data     = rd_q;
    assign busy        = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_RECV);
    assign done        = (state_q == S_DONE);
    assign err_timeout = err_t_q;
    assign err_short   = err_s_q;
    assign gs_in_en    = en_q;
    assign gs_b_in     = b_q;

endmodule

// File: tb/tb_gsim_host_link.sv
// tb/tb_gsim_host_link.sv - randomized self-checking bench for gsim_host_link
module tb_gsim_host_link;
    localparam int N  = 16;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy, done, err_timeout, err_short, gs_in_en;
    logic [15:0] gs_b_in;
    logic        gs_out_valid = 1'b0;
    logic [31:0] gs_x_out = '0;

    logic [15:0] bmodel [N];
    logic [31:0] xmodel [N];
    int n_tests = 0;
    int n_fail  = 0;

    gsim_host_link #(.N(N), .B_W(16), .X_W(32), .TIMEOUT(TO), .CNT_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_short(err_short), .gs_in_en(gs_in_en),
        .gs_b_in(gs_b_in), .gs_out_valid(gs_out_valid), .gs_x_out(gs_x_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            bmodel[i] = '0;
            xmodel[i] = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_eto"}, 64'(err_timeout), 64'd0);
        check({tag, "_esh"}, 64'(err_short), 64'd0);
        check({tag, "_en"}, 64'(gs_in_en), 64'd0);
        check({tag, "_b"}, 64'(gs_b_in), 64'd0);
        check({tag, "_rd"}, 64'(rd_data), 64'd0);
    endtask

    task automatic write_b(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        bmodel[a] = d;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            check($sformatf("%s_x%0d", tag, i), 64'(rd_data), 64'(xmodel[i]));
        end
    endtask

    // d: WAIT cycle (tcnt value) on which the first result beat appears
    task automatic run(input int d, input int beats, input bit ramp, input bit disturb, input int rst_beat);
        bit exp_to, exp_sh;
        logic [31:0] x;
        exp_to = (d >= TO) || (beats == 0);
        exp_sh = !exp_to && (beats < N);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == rst_beat) begin
                rst_n = 1'b0;
                #1;
                clear_model();
                check_reset_outputs("midrst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (disturb && k == 5) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = ~bmodel[3];
            end else if (disturb && k == 6) begin
                start = 1'b0; wr_en = 1'b0;
            end
            check($sformatf("send_en%0d", k), 64'(gs_in_en), 64'd1);
            check($sformatf("send_b%0d", k), 64'(gs_b_in), 64'(bmodel[k]));
            @(negedge clk);
        end
        check("wait_en", 64'(gs_in_en), 64'd0);
        check("wait_b", 64'(gs_b_in), 64'd0);
        check("wait_busy", 64'(busy), 64'd1);
        check("wait_errs", 64'({err_timeout, err_short}), 64'd0);
        if (exp_to) begin
            for (int c = 0; c < TO; c++) begin
                if (c == TO - 1) check("to_early", 64'(done), 64'd0);
                @(negedge clk);
            end
        end else begin
            for (int c = 0; c < d; c++) @(negedge clk);
            for (int j = 0; j < beats; j++) begin
                gs_out_valid = 1'b1;
                x = ramp ? 32'h0001_0000 * 32'(j) : $urandom;
                gs_x_out = x;
                if (j < N) xmodel[j] = x;
                check($sformatf("done_at_beat%0d", j), 64'(done), 64'(j >= N));
                @(negedge clk);
            end
            gs_out_valid = 1'b0;
            gs_x_out = '0;
            @(negedge clk);
        end
        check("end_done", 64'(done), 64'd1);
        check("end_busy", 64'(busy), 64'd0);
        check("end_eto", 64'(err_timeout), 64'(exp_to));
        check("end_esh", 64'(err_short), 64'(exp_sh));
        read_all("rd");
    endtask

    initial begin
        int sel, beats, d;
        clear_model();
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        read_all("rst");

        for (int k = 0; k < N; k++) write_b(4'(k), 16'(k + 1));
        run(40, N, 1'b1, 1'b0, -1);
        run(TO, 0, 1'b0, 1'b0, -1);
        run(3, 10, 1'b0, 1'b0, -1);
        run(5, N, 1'b0, 1'b1, -1);
        run(5, N, 1'b0, 1'b0, 7);
        for (int k = 0; k < N; k++) write_b(4'(k), 16'($urandom));
        run(TO - 1, N, 1'b0, 1'b0, -1);
        run(2, N + 2, 1'b0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 6; w++) write_b(4'($urandom_range(0, N - 1)), 16'($urandom));
            sel = $urandom_range(0, 3);
            d = $urandom_range(0, TO + 5);
            case (sel)
                0: beats = N;
                1: beats = $urandom_range(1, N - 1);
                2: beats = N + 2;
                default: beats = 0;
            endcase
            run(d, beats, 1'b0, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
